// File: rtl/simple_bus_pkg.sv
// Shared types for the simple_bus slice.
// The registered response kind replaces the legacy valid/err flag pair.
package simple_bus_pkg;

  typedef enum logic [1:0] {
    RespNone     = 2'd0,
    RespDevice   = 2'd1,
    RespUnmapped = 2'd2
  } resp_kind_e;

endpackage

// File: rtl/simple_bus_if.sv
// Bundle of host-side and device-side bus signals for simple_bus.
// The master modport is the host view, the slave modport is the device view.
interface simple_bus_if #(
  parameter int unsigned NrHosts      = 1,
  parameter int unsigned NrDevices    = 1,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32
);
  logic                    host_req      [NrHosts];
  logic                    host_gnt      [NrHosts];
  logic [AddressWidth-1:0] host_addr     [NrHosts];
  logic                    host_we       [NrHosts];
  logic [DataWidth/8-1:0]  host_be       [NrHosts];
  logic [DataWidth-1:0]    host_wdata    [NrHosts];
  logic                    host_rvalid   [NrHosts];
  logic [DataWidth-1:0]    host_rdata    [NrHosts];
  logic                    host_err      [NrHosts];

  logic                    device_req    [NrDevices];
  logic [AddressWidth-1:0] device_addr   [NrDevices];
  logic                    device_we     [NrDevices];
  logic [DataWidth/8-1:0]  device_be     [NrDevices];
  logic [DataWidth-1:0]    device_wdata  [NrDevices];
  logic                    device_rvalid [NrDevices];
  logic [DataWidth-1:0]    device_rdata  [NrDevices];
  logic                    device_err    [NrDevices];

  modport master (
    output host_req, host_addr, host_we, host_be, host_wdata,
    input  host_gnt, host_rvalid, host_rdata, host_err
  );

  modport slave (
    input  device_req, device_addr, device_we, device_be, device_wdata,
    output device_rvalid, device_rdata, device_err
  );

endinterface

// File: rtl/simple_bus.sv
// Fixed-priority multi-host to multi-device bus with zero-wait grant and
// single-cycle device responses routed back by the indices captured at grant.
module simple_bus
  import simple_bus_pkg::*;
#(
  parameter int unsigned NrDevices    = 1,
  parameter int unsigned NrHosts      = 1,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,

  input  logic                    host_req_i           [NrHosts],
  output logic                    host_gnt_o           [NrHosts],
  input  logic [AddressWidth-1:0] host_addr_i          [NrHosts],
  input  logic                    host_we_i            [NrHosts],
  input  logic [DataWidth/8-1:0]  host_be_i            [NrHosts],
  input  logic [DataWidth-1:0]    host_wdata_i         [NrHosts],
  output logic                    host_rvalid_o        [NrHosts],
  output logic [DataWidth-1:0]    host_rdata_o         [NrHosts],
  output logic                    host_err_o           [NrHosts],

  output logic                    device_req_o         [NrDevices],
  output logic [AddressWidth-1:0] device_addr_o        [NrDevices],
  output logic                    device_we_o          [NrDevices],
  output logic [DataWidth/8-1:0]  device_be_o          [NrDevices],
  output logic [DataWidth-1:0]    device_wdata_o       [NrDevices],
  input  logic                    device_rvalid_i      [NrDevices],
  input  logic [DataWidth-1:0]    device_rdata_i       [NrDevices],
  input  logic                    device_err_i         [NrDevices],

  input  logic [AddressWidth-1:0] cfg_device_addr_base [NrDevices],
  input  logic [AddressWidth-1:0] cfg_device_addr_mask [NrDevices]
);

  localparam int unsigned HostIdxW = (NrHosts   > 1) ? $clog2(NrHosts)   : 1;
  localparam int unsigned DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;

  logic                    host_sel_valid;
  logic [HostIdxW-1:0]     host_sel;
  logic [AddressWidth-1:0] sel_addr;
  logic                    sel_we;
  logic [DataWidth/8-1:0]  sel_be;
  logic [DataWidth-1:0]    sel_wdata;

  logic                    dev_sel_valid;
  logic [DevIdxW-1:0]      dev_sel;

  resp_kind_e              resp_kind_d, resp_kind_q;
  logic [HostIdxW-1:0]     host_idx_d, host_idx_q;
  logic [DevIdxW-1:0]      dev_idx_d, dev_idx_q;

  logic                    rsp_valid;
  logic [DataWidth-1:0]    rsp_rdata;
  logic                    rsp_err;

  // Lowest index wins; the winner's request fields are muxed out in the same pass.
  always_comb begin
    host_sel_valid = 1'b0;
    host_sel       = '0;
    sel_addr       = '0;
    sel_we         = 1'b0;
    sel_be         = '0;
    sel_wdata      = '0;
    for (int unsigned h = 0; h < NrHosts; h++) begin
      if (!host_sel_valid && host_req_i[h]) begin
        host_sel_valid = 1'b1;
        host_sel       = HostIdxW'(h);
        sel_addr       = host_addr_i[h];
        sel_we         = host_we_i[h];
        sel_be         = host_be_i[h];
        sel_wdata      = host_wdata_i[h];
      end
    end
  end

  always_comb begin
    dev_sel_valid = 1'b0;
    dev_sel       = '0;
    for (int unsigned d = 0; d < NrDevices; d++) begin
      if (!dev_sel_valid &&
          ((sel_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d])) begin
        dev_sel_valid = 1'b1;
        dev_sel       = DevIdxW'(d);
      end
    end
  end

  always_comb begin
    for (int unsigned h = 0; h < NrHosts; h++) begin
      host_gnt_o[h] = host_sel_valid && (host_sel == HostIdxW'(h));
    end
    for (int unsigned d = 0; d < NrDevices; d++) begin
      device_req_o[d]   = host_sel_valid && dev_sel_valid && (dev_sel == DevIdxW'(d));
      device_addr_o[d]  = device_req_o[d] ? sel_addr  : '0;
      device_we_o[d]    = device_req_o[d] && sel_we;
      device_be_o[d]    = device_req_o[d] ? sel_be    : '0;
      device_wdata_o[d] = device_req_o[d] ? sel_wdata : '0;
    end
  end

  // Indices hold between grants; only the response kind returns to idle.
  always_comb begin
    resp_kind_d = RespNone;
    host_idx_d  = host_idx_q;
    dev_idx_d   = dev_idx_q;
    if (host_sel_valid) begin
      host_idx_d  = host_sel;
      dev_idx_d   = dev_sel;
      resp_kind_d = dev_sel_valid ? RespDevice : RespUnmapped;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_kind_q <= RespNone;
      host_idx_q  <= '0;
      dev_idx_q   <= '0;
    end else begin
      resp_kind_q <= resp_kind_d;
      host_idx_q  <= host_idx_d;
      dev_idx_q   <= dev_idx_d;
    end
  end

  always_comb begin
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    for (int unsigned d = 0; d < NrDevices; d++) begin
      if (dev_idx_q == DevIdxW'(d)) begin
        rsp_valid = device_rvalid_i[d];
        rsp_rdata = device_rdata_i[d];
        rsp_err   = device_err_i[d];
      end
    end
  end

  always_comb begin
    for (int unsigned h = 0; h < NrHosts; h++) begin
      host_rvalid_o[h] = 1'b0;
      host_rdata_o[h]  = '0;
      host_err_o[h]    = 1'b0;
      if (host_idx_q == HostIdxW'(h)) begin
        case (resp_kind_q)
          RespDevice: begin
            host_rvalid_o[h] = rsp_valid;
            host_rdata_o[h]  = rsp_rdata;
            host_err_o[h]    = rsp_err;
          end
          RespUnmapped: begin
            host_rvalid_o[h] = 1'b1;
            host_err_o[h]    = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_simple_bus.sv
// Self-checking bench for simple_bus: 2 hosts, 3 devices, rule-level model
// compared every cycle plus directed literal expectations.
module tb_simple_bus;

  localparam int unsigned NH = 2;
  localparam int unsigned ND = 3;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic [AW-1:0] cfg_base [ND];
  logic [AW-1:0] cfg_mask [ND];
  logic stray_en = 1'b0;

  simple_bus_if #(.NrHosts(NH), .NrDevices(ND), .DataWidth(DW), .AddressWidth(AW)) bus ();

  simple_bus #(
    .NrDevices(ND), .NrHosts(NH), .DataWidth(DW), .AddressWidth(AW)
  ) dut (
    .clk_i               (clk),
    .rst_ni              (rst_ni),
    .host_req_i          (bus.host_req),
    .host_gnt_o          (bus.host_gnt),
    .host_addr_i         (bus.host_addr),
    .host_we_i           (bus.host_we),
    .host_be_i           (bus.host_be),
    .host_wdata_i        (bus.host_wdata),
    .host_rvalid_o       (bus.host_rvalid),
    .host_rdata_o        (bus.host_rdata),
    .host_err_o          (bus.host_err),
    .device_req_o        (bus.device_req),
    .device_addr_o       (bus.device_addr),
    .device_we_o         (bus.device_we),
    .device_be_o         (bus.device_be),
    .device_wdata_o      (bus.device_wdata),
    .device_rvalid_i     (bus.device_rvalid),
    .device_rdata_i      (bus.device_rdata),
    .device_err_i        (bus.device_err),
    .cfg_device_addr_base(cfg_base),
    .cfg_device_addr_mask(cfg_mask)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] dev_data(input int unsigned d, input logic [AW-1:0] a);
    if (d == 0) return 32'hDEADBEEF;
    return 32'hC000_0000 | (32'(d) << 24) | {8'h00, a[23:0]};
  endfunction

  function automatic logic dev_err(input logic [AW-1:0] a);
    return a[7:0] == 8'hEE;
  endfunction

  // Device models: respond one cycle after a request; optional stray response on device 1.
  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (bus.device_req[d]) begin
        bus.device_rvalid[d] <= 1'b1;
        bus.device_rdata[d]  <= dev_data(d, bus.device_addr[d]);
        bus.device_err[d]    <= dev_err(bus.device_addr[d]);
      end else if (stray_en && d == 1) begin
        bus.device_rvalid[d] <= 1'b1;
        bus.device_rdata[d]  <= 32'hBAD0_0001;
        bus.device_err[d]    <= 1'b1;
      end else begin
        bus.device_rvalid[d] <= 1'b0;
        bus.device_rdata[d]  <= 32'hBAD0_0000 | 32'(d);
        bus.device_err[d]    <= 1'b0;
      end
    end
  end

  // Model: outstanding transaction from the previous cycle plus this cycle's arbitration.
  bit            pend_valid = 1'b0;
  bit            pend_mapped;
  int            pend_host;
  int            pend_dev;
  logic [AW-1:0] pend_addr;

  always @(negedge clk) begin : model
    int            win;
    int            dec;
    logic [AW-1:0] waddr;
    logic          ev;
    logic [DW-1:0] ed;
    logic          ee;
    logic          er;
    if (!rst_ni) pend_valid = 1'b0;
    for (int h = 0; h < NH; h++) begin
      ev = pend_valid && (pend_host == h);
      ed = (ev && pend_mapped) ? dev_data(pend_dev, pend_addr) : '0;
      ee = ev && (pend_mapped ? dev_err(pend_addr) : 1'b1);
      check($sformatf("host_rvalid[%0d]", h), bus.host_rvalid[h], ev);
      check($sformatf("host_rdata[%0d]", h),  bus.host_rdata[h],  ed);
      check($sformatf("host_err[%0d]", h),    bus.host_err[h],    ee);
    end
    win = -1;
    for (int h = 0; h < NH; h++) if (win < 0 && bus.host_req[h]) win = h;
    waddr = (win >= 0) ? bus.host_addr[win] : '0;
    dec = -1;
    if (win >= 0)
      for (int d = 0; d < ND; d++)
        if (dec < 0 && ((waddr & cfg_mask[d]) == cfg_base[d])) dec = d;
    for (int h = 0; h < NH; h++)
      check($sformatf("host_gnt[%0d]", h), bus.host_gnt[h], win == h);
    for (int d = 0; d < ND; d++) begin
      er = (dec == d);
      check($sformatf("device_req[%0d]", d),   bus.device_req[d],   er);
      check($sformatf("device_addr[%0d]", d),  bus.device_addr[d],  er ? waddr : '0);
      check($sformatf("device_we[%0d]", d),    bus.device_we[d],    er ? bus.host_we[win] : 1'b0);
      check($sformatf("device_be[%0d]", d),    bus.device_be[d],    er ? bus.host_be[win] : 4'h0);
      check($sformatf("device_wdata[%0d]", d), bus.device_wdata[d], er ? bus.host_wdata[win] : 32'h0);
    end
    pend_valid  = rst_ni && (win >= 0);
    pend_host   = win;
    pend_dev    = dec;
    pend_mapped = dec >= 0;
    pend_addr   = waddr;
  end

  task automatic idle_hosts();
    for (int h = 0; h < NH; h++) begin
      bus.host_req[h]   = 1'b0;
      bus.host_addr[h]  = '0;
      bus.host_we[h]    = 1'b0;
      bus.host_be[h]    = '0;
      bus.host_wdata[h] = '0;
    end
  endtask

  task automatic drive(input int h, input logic [AW-1:0] a, input logic we,
                       input logic [3:0] be, input logic [DW-1:0] wd);
    bus.host_req[h]   = 1'b1;
    bus.host_addr[h]  = a;
    bus.host_we[h]    = we;
    bus.host_be[h]    = be;
    bus.host_wdata[h] = wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    cfg_base = '{32'h0010_0000, 32'h0002_0000, 32'h0003_0000};
    cfg_mask = '{32'hFFF0_0000, 32'hFFFF_FC00, 32'hFFFF_FC00};
    idle_hosts();
    rst_ni = 1'b0;

    // Combinational path follows inputs during reset; response stays quiet.
    drive(0, 32'h0010_0010, 1'b0, 4'hF, '0);
    at_neg();
    check("rst_gnt0", bus.host_gnt[0], 1'b1);
    check("rst_dreq0", bus.device_req[0], 1'b1);
    step(); step();
    at_neg();
    check("rst_rvalid0", bus.host_rvalid[0], 1'b0);
    check("rst_err1", bus.host_err[1], 1'b0);
    step(); idle_hosts(); rst_ni = 1'b1;
    at_neg();
    check("release_rvalid0", bus.host_rvalid[0], 1'b0);

    // Single read from device 0.
    step(); drive(0, 32'h0010_0010, 1'b0, 4'hF, '0);
    at_neg();
    check("rd_gnt0", bus.host_gnt[0], 1'b1);
    check("rd_dreq0", bus.device_req[0], 1'b1);
    check("rd_daddr0", bus.device_addr[0], 32'h0010_0010);
    step(); idle_hosts();
    at_neg();
    check("rd_rvalid0", bus.host_rvalid[0], 1'b1);
    check("rd_rdata0", bus.host_rdata[0], 32'hDEADBEEF);

    // Contention: host0 first, host1 the following cycle.
    step(); drive(0, 32'h0002_0004, 1'b0, 4'hF, '0); drive(1, 32'h0003_0008, 1'b0, 4'hF, '0);
    at_neg();
    check("arb_gnt0", bus.host_gnt[0], 1'b1);
    check("arb_gnt1", bus.host_gnt[1], 1'b0);
    check("arb_dreq1", bus.device_req[1], 1'b1);
    step(); bus.host_req[0] = 1'b0;
    at_neg();
    check("arb2_gnt1", bus.host_gnt[1], 1'b1);
    check("arb2_dreq2", bus.device_req[2], 1'b1);
    check("arb2_rdata0", bus.host_rdata[0], 32'hC102_0004);
    check("arb2_rvalid1", bus.host_rvalid[1], 1'b0);
    step(); idle_hosts();
    at_neg();
    check("arb3_rvalid1", bus.host_rvalid[1], 1'b1);
    check("arb3_rdata1", bus.host_rdata[1], 32'hC203_0008);

    // Write forwarded to device 2.
    step(); drive(0, 32'h0003_0000, 1'b1, 4'hF, 32'h1234_5678);
    at_neg();
    check("wr_daddr2", bus.device_addr[2], 32'h0003_0000);
    check("wr_dwe2", bus.device_we[2], 1'b1);
    check("wr_dbe2", bus.device_be[2], 4'hF);
    check("wr_dwdata2", bus.device_wdata[2], 32'h1234_5678);
    check("wr_daddr0", bus.device_addr[0], 32'h0);
    step(); idle_hosts();
    at_neg();
    check("wr_rvalid0", bus.host_rvalid[0], 1'b1);
    check("wr_err0", bus.host_err[0], 1'b0);

    // Unmapped access.
    step(); drive(1, 32'h8000_0000, 1'b0, 4'hF, '0);
    at_neg();
    check("um_gnt1", bus.host_gnt[1], 1'b1);
    check("um_dreq0", bus.device_req[0], 1'b0);
    check("um_dreq1", bus.device_req[1], 1'b0);
    check("um_dreq2", bus.device_req[2], 1'b0);
    step(); idle_hosts();
    at_neg();
    check("um_rvalid1", bus.host_rvalid[1], 1'b1);
    check("um_err1", bus.host_err[1], 1'b1);
    check("um_rdata1", bus.host_rdata[1], 32'h0);

    // Stray device response with nothing outstanding.
    step(); stray_en = 1'b1;
    step(); stray_en = 1'b0;
    at_neg();
    check("stray_rvalid0", bus.host_rvalid[0], 1'b0);
    check("stray_rvalid1", bus.host_rvalid[1], 1'b0);
    check("stray_err1", bus.host_err[1], 1'b0);

    // Back-to-back from host0, including a device error and an unmapped hit.
    step(); drive(0, 32'h0010_0040, 1'b0, 4'hF, '0);
    step(); drive(0, 32'h0002_00EE, 1'b0, 4'h3, '0);
    step(); drive(0, 32'h0003_0010, 1'b1, 4'hC, 32'hA5A5_5A5A);
    at_neg();
    check("b2b_rvalid0", bus.host_rvalid[0], 1'b1);
    check("b2b_err0", bus.host_err[0], 1'b1);
    check("b2b_rdata0", bus.host_rdata[0], 32'hC102_00EE);
    step(); drive(0, 32'h9000_0000, 1'b0, 4'hF, '0);
    step(); idle_hosts();
    step();

    // Overlapping windows: lowest device index wins.
    cfg_base[2] = 32'h0002_0000;
    drive(1, 32'h0002_0010, 1'b0, 4'hF, '0);
    at_neg();
    check("ovl_dreq1", bus.device_req[1], 1'b1);
    check("ovl_dreq2", bus.device_req[2], 1'b0);
    step(); idle_hosts(); cfg_base[2] = 32'h0003_0000;
    at_neg();
    check("ovl_rvalid1", bus.host_rvalid[1], 1'b1);

    // Reset right after a grant drops the response.
    step(); drive(0, 32'h0010_0020, 1'b0, 4'hF, '0);
    step(); idle_hosts(); rst_ni = 1'b0;
    at_neg();
    check("rr_rvalid0", bus.host_rvalid[0], 1'b0);
    check("rr_err0", bus.host_err[0], 1'b0);
    step(); rst_ni = 1'b1;
    at_neg();
    check("rr_release_rvalid0", bus.host_rvalid[0], 1'b0);
    step(); drive(1, 32'h0003_0004, 1'b0, 4'hF, '0);
    step(); idle_hosts();
    at_neg();
    check("rr_rvalid1", bus.host_rvalid[1], 1'b1);
    check("rr_rdata1", bus.host_rdata[1], 32'hC203_0004);
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
